arm_mc_controller: RTL and testbench
====================================

ARM_MC_CONTROLLER -- requirements
Module: arm_mc_controller

Interface
REQ-001 Parameter: MEM_HANDSHAKE, default 1, meaning 1 = FETCH/MEMRD/MEMWR stall until MemReady; 0 = MemReady ignored and each memory state lasts exactly one cycle.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-004 Instr  in  20  Instr[31:12] from the IR: Cond[19:16], Op[15:14], Funct[13:8], Rd[3:0].
REQ-005 ALUFlags  in  4  NZCV from the ALU in the current cycle.
REQ-006 MemReady  in  1  memory completes the current access this cycle.
REQ-007 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Mov, Illegal  out  1 each  datapath strobes and selects.
REQ-008 ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl  out  2 each  datapath selects; ALUControl: 00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-009 Flags  out  4  architectural NZCV register.

Function
REQ-010 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-011 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10; IRWrite=PCWrite=1 only in the completing cycle (MemReady=1, or always if MEM_HANDSHAKE=0); then DECODE.
REQ-012 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ImmSrc=Op, RegSrc={Op==01, Op==10}; next: Op=01 -> MEMADR; Op=10 -> BRANCH; Op=00 -> EXECI if Funct[5] else EXECR; Op=11 -> FETCH with Illegal=1 for that cycle.
REQ-013 DP cmd Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV (ALUControl=00, Mov=1); any other cmd SHALL behave as Op=11 (Illegal, return to FETCH).
REQ-014 EXECR: ALUSrcA=0, ALUSrcB=00; EXECI: ALUSrcA=0, ALUSrcB=01; both -> ALUWB.
REQ-015 ALUWB: ResultSrc=00, RegWrite=CondEx; PCWrite=CondEx when Rd=1111; -> FETCH.
REQ-016 MEMADR: ALUSrcA=0, ALUSrcB=01, ADD; -> MEMRD if Funct[0] else MEMWR.
REQ-017 MEMRD: AdrSrc=1; hold until complete; -> MEMWB. MEMWB: ResultSrc=01, RegWrite=CondEx, PCWrite=CondEx when Rd=1111; -> FETCH.
REQ-018 MEMWR: AdrSrc=1, MemWrite=CondEx held every cycle until complete; -> FETCH.
REQ-019 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx; -> FETCH.
REQ-020 CondEx SHALL evaluate Cond against registered Flags per ARM (EQ..LE, AL=1110 true); Cond=1111 SHALL be false.
REQ-021 Flags update at end of EXECR/EXECI only when Funct[0]=1 and CondEx: N,Z always; C,V only for ADD/SUB/MOV-free arithmetic (ALUControl 00/01, Mov=0).
REQ-022 Outputs not listed for a state SHALL be 0; outputs are Moore except CondEx/MemReady gating.
REQ-023 Latency: DP 4 cycles, LDR 5, STR 4, B 3, Illegal 2, plus stall cycles.

Reset
REQ-024 reset=0 at a rising edge SHALL force state FETCH and Flags=0000 regardless of current state, including mid-stall.
REQ-025 While reset=0, PCWrite, MemWrite, IRWrite, RegWrite SHALL be 0; all other outputs 0.

Configuration
REQ-026 Macro ARM_MC_PERF_EN defined: add output InstrCount (32 bits), reset 0, +1 on every transition into FETCH from a completing state except from DECODE-illegal, wraps 0xFFFFFFFF -> 0.
REQ-027 ARM_MC_PERF_EN undefined: InstrCount port and counter SHALL not exist.

Verification
REQ-028 ADD R1,R2,R3 (Cond=1110, MEM_HANDSHAKE=0) -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB; 4 cycles.
REQ-029 LDR with MemReady low 3 cycles in MEMRD -> MEMRD held 4 cycles, MEMWB RegWrite=1 once.
REQ-030 SUBS giving zero then BEQ -> Flags=0100 after EXECR; BRANCH PCWrite=1; BNE -> PCWrite=0.
REQ-031 STR with Cond=0000 and Z=0 -> MemWrite stays 0 throughout MEMWR.
REQ-032 Op=11 -> Illegal=1 in DECODE, next state FETCH; reset=0 asserted in MEMRD -> FETCH next cycle, Flags=0000, InstrCount=0.

Source files
------------

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main FSM, DP decode, condition check and NZCV register.
// Define ARM_MC_PERF_EN to add the InstrCount retired-instruction counter output.
module arm_mc_controller #(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        Mov,
    output logic        Illegal,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  Flags
`ifdef ARM_MC_PERF_EN
    ,
    output logic [31:0] InstrCount
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  flags_reg, flags_next;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        mem_done;
    logic        cond_ex;
    logic        dp_legal;
    logic        dp_mov;
    logic [1:0]  dp_ctl;
    logic        decode_illegal;
    logic        unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    // Without the handshake every memory state completes in its first cycle.
    assign mem_done = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

    always_comb begin
        dp_legal = 1'b1;
        dp_mov   = 1'b0;
        dp_ctl   = 2'b00;
        case (funct[4:1])
            4'b0100: dp_ctl = 2'b00;
            4'b0010: dp_ctl = 2'b01;
            4'b0000: dp_ctl = 2'b10;
            4'b1100: dp_ctl = 2'b11;
            4'b1101: dp_mov = 1'b1;
            default: dp_legal = 1'b0;
        endcase
    end

    assign decode_illegal = (op == 2'b11) || ((op == 2'b00) && !dp_legal);

    always_comb begin
        case (cond)
            4'b0000: cond_ex = flags_reg[2];
            4'b0001: cond_ex = !flags_reg[2];
            4'b0010: cond_ex = flags_reg[1];
            4'b0011: cond_ex = !flags_reg[1];
            4'b0100: cond_ex = flags_reg[3];
            4'b0101: cond_ex = !flags_reg[3];
            4'b0110: cond_ex = flags_reg[0];
            4'b0111: cond_ex = !flags_reg[0];
            4'b1000: cond_ex = flags_reg[1] && !flags_reg[2];
            4'b1001: cond_ex = !flags_reg[1] || flags_reg[2];
            4'b1010: cond_ex = (flags_reg[3] == flags_reg[0]);
            4'b1011: cond_ex = (flags_reg[3] != flags_reg[0]);
            4'b1100: cond_ex = !flags_reg[2] && (flags_reg[3] == flags_reg[0]);
            4'b1101: cond_ex = flags_reg[2] || (flags_reg[3] != flags_reg[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_FETCH;
            flags_reg <= 4'b0000;
        end else begin
            state_reg <= state_next;
            flags_reg <= flags_next;
        end
    end

    // C and V only come from true arithmetic; logical ops and MOV keep them.
    always_comb begin
        flags_next = flags_reg;
        if (((state_reg == S_EXECR) || (state_reg == S_EXECI)) && funct[0] && cond_ex) begin
            flags_next[3:2] = ALUFlags[3:2];
            if (!dp_mov && !dp_ctl[1])
                flags_next[1:0] = ALUFlags[1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (mem_done) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b01:   state_next = S_MEMADR;
                    2'b10:   state_next = S_BRANCH;
                    2'b00:   state_next = !dp_legal ? S_FETCH : (funct[5] ? S_EXECI : S_EXECR);
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_done) state_next = S_MEMWB;
            S_MEMWR:  if (mem_done) state_next = S_FETCH;
            S_EXECR,
            S_EXECI:  state_next = S_ALUWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        Mov        = 1'b0;
        Illegal    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = 2'b00;
        Flags      = 4'b0000;
        if (reset) begin
            Flags = flags_reg;
            case (state_reg)
                S_FETCH: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_done;
                    PCWrite   = mem_done;
                end
                S_DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    ImmSrc    = op;
                    RegSrc    = {op == 2'b01, op == 2'b10};
                    Illegal   = decode_illegal;
                end
                S_EXECR: begin
                    ALUControl = dp_ctl;
                    Mov        = dp_mov;
                end
                S_EXECI: begin
                    ALUSrcB    = 2'b01;
                    ALUControl = dp_ctl;
                    Mov        = dp_mov;
                end
                S_ALUWB: begin
                    RegWrite = cond_ex;
                    PCWrite  = cond_ex && (rd == 4'hF);
                end
                S_MEMADR: ALUSrcB = 2'b01;
                S_MEMRD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = cond_ex;
                    PCWrite   = cond_ex && (rd == 4'hF);
                end
                S_MEMWR: begin
                    AdrSrc   = 1'b1;
                    MemWrite = cond_ex;
                end
                S_BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = cond_ex;
                end
                default: ;
            endcase
        end
    end

`ifdef ARM_MC_PERF_EN
    logic [31:0] instr_count_reg;
    logic        retire;

    // Illegal decodes return to FETCH without retiring anything.
    assign retire = (state_next == S_FETCH) &&
                    ((state_reg == S_ALUWB) || (state_reg == S_MEMWB) ||
                     (state_reg == S_BRANCH) || (state_reg == S_MEMWR));

    always_ff @(posedge clk) begin
        if (!reset)
            instr_count_reg <= 32'd0;
        else if (retire)
            instr_count_reg <= instr_count_reg + 32'd1;
    end

    assign InstrCount = reset ? instr_count_reg : 32'd0;
`endif

endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench for arm_mc_controller: per-instruction phase lists built from the
// instruction class, checked cycle by cycle on a handshake DUT and a no-handshake DUT.
`timescale 1ns/1ps
module tb_arm_mc_controller;

    typedef enum {PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB,
                  PH_MEMWR, PH_EXECR, PH_EXECI, PH_ALUWB, PH_BRANCH} ph_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemReady = 1'b0;
    logic [19:0] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    wire  [21:0] o1;
    wire  [21:0] o0;
`ifdef ARM_MC_PERF_EN
    wire  [31:0] c1, c0;
    logic [31:0] mcnt [0:1];
`endif

    int errors = 0;
    int checks = 0;
    logic [3:0] mflags [0:1];

    always #5 clk = ~clk;

    arm_mc_controller #(.MEM_HANDSHAKE(1)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(o1[21]), .AdrSrc(o1[20]), .MemWrite(o1[19]), .IRWrite(o1[18]),
        .RegWrite(o1[17]), .ALUSrcA(o1[16]), .Mov(o1[15]), .Illegal(o1[14]),
        .ResultSrc(o1[13:12]), .ALUSrcB(o1[11:10]), .ImmSrc(o1[9:8]), .RegSrc(o1[7:6]),
        .ALUControl(o1[5:4]), .Flags(o1[3:0])
`ifdef ARM_MC_PERF_EN
        , .InstrCount(c1)
`endif
    );

    arm_mc_controller #(.MEM_HANDSHAKE(0)) dut_nohs (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(o0[21]), .AdrSrc(o0[20]), .MemWrite(o0[19]), .IRWrite(o0[18]),
        .RegWrite(o0[17]), .ALUSrcA(o0[16]), .Mov(o0[15]), .Illegal(o0[14]),
        .ResultSrc(o0[13:12]), .ALUSrcB(o0[11:10]), .ImmSrc(o0[9:8]), .RegSrc(o0[7:6]),
        .ALUControl(o0[5:4]), .Flags(o0[3:0])
`ifdef ARM_MC_PERF_EN
        , .InstrCount(c0)
`endif
    );

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {legal, mov, alu_control} for a data-processing command.
    function automatic logic [3:0] dp_info(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 4'b1000;
            4'b0010: return 4'b1001;
            4'b0000: return 4'b1010;
            4'b1100: return 4'b1011;
            4'b1101: return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [21:0] expect_out(input ph_t ph, input logic [19:0] ins,
                                               input logic [3:0] fl, input bit mr, input bit hs);
        logic pcw, adr, mw, irw, rw, asa, mov, ill;
        logic [1:0] rs, asb, imm, rsrc, ctl, op;
        logic [3:0] dp;
        bit ce;
        {pcw, adr, mw, irw, rw, asa, mov, ill} = '0;
        {rs, asb, imm, rsrc, ctl} = '0;
        op = ins[15:14];
        dp = dp_info(ins[12:9]);
        ce = cond_true(ins[19:16], fl);
        case (ph)
            PH_FETCH:  begin asa = 1; asb = 2'b10; rs = 2'b10; irw = mr || !hs; pcw = irw; end
            PH_DECODE: begin
                asa = 1; asb = 2'b10; rs = 2'b10; imm = op;
                rsrc = {op == 2'b01, op == 2'b10};
                ill = (op == 2'b11) || (op == 2'b00 && !dp[3]);
            end
            PH_EXECR:  begin ctl = dp[1:0]; mov = dp[2]; end
            PH_EXECI:  begin asb = 2'b01; ctl = dp[1:0]; mov = dp[2]; end
            PH_ALUWB:  begin rw = ce; pcw = ce && (ins[3:0] == 4'hF); end
            PH_MEMADR: asb = 2'b01;
            PH_MEMRD:  adr = 1;
            PH_MEMWB:  begin rs = 2'b01; rw = ce; pcw = ce && (ins[3:0] == 4'hF); end
            PH_MEMWR:  begin adr = 1; mw = ce; end
            PH_BRANCH: begin asb = 2'b01; rs = 2'b10; pcw = ce; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, rw, asa, mov, ill, rs, asb, imm, rsrc, ctl, fl};
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        MemReady = 1'($urandom);
        ALUFlags = 4'($urandom);
        @(negedge clk);
        checks++;
        if (o1 !== 22'd0) begin errors++; $display("FAIL reset_outputs_hs got=%h want=0", o1); end
        checks++;
        if (o0 !== 22'd0) begin errors++; $display("FAIL reset_outputs_nohs got=%h want=0", o0); end
        mflags[0] = 4'd0;
        mflags[1] = 4'd0;
`ifdef ARM_MC_PERF_EN
        mcnt[0] = 32'd0;
        mcnt[1] = 32'd0;
`endif
    endtask

    task automatic step(input ph_t ph, input logic [19:0] ins, input bit mr, input logic [3:0] af,
                        input bit hs, output bit done, output logic [21:0] obs);
        logic [21:0] exp;
        logic [3:0] dp;
        bit ce;
        @(posedge clk); #1;
        reset = 1'b1; Instr = ins; MemReady = mr; ALUFlags = af;
        @(negedge clk);
        obs = hs ? o1 : o0;
        exp = expect_out(ph, ins, mflags[hs], mr, hs);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL cycle_%s hs=%0d instr=%h got=%h want=%h", ph.name(), hs, ins, obs, exp);
        end
`ifdef ARM_MC_PERF_EN
        checks++;
        if ((hs ? c1 : c0) !== mcnt[hs]) begin
            errors++;
            $display("FAIL instr_count hs=%0d got=%0d want=%0d", hs, (hs ? c1 : c0), mcnt[hs]);
        end
`endif
        ce = cond_true(ins[19:16], mflags[hs]);
        dp = dp_info(ins[12:9]);
        done = !(ph inside {PH_FETCH, PH_MEMRD, PH_MEMWR}) || !hs || mr;
        if ((ph == PH_EXECR || ph == PH_EXECI) && ins[8] && ce) begin
            mflags[hs][3:2] = af[3:2];
            if (!dp[2] && !dp[1]) mflags[hs][1:0] = af[1:0];
        end
`ifdef ARM_MC_PERF_EN
        if (done && (ph inside {PH_ALUWB, PH_MEMWB, PH_MEMWR, PH_BRANCH})) mcnt[hs] = mcnt[hs] + 1;
`endif
    endtask

    // mlow >= 0: MemReady low for the first mlow cycles of every phase; mlow < 0: random.
    task automatic run_instr(input logic [19:0] ins, input bit hs, input int mlow,
                             input bit rand_af, input logic [3:0] af_fix,
                             output int cyc, output int rw, output int adr,
                             output int mw, output int pcw);
        ph_t q[$];
        logic [1:0] op;
        logic [5:0] fn;
        logic [21:0] obs;
        logic [3:0] af;
        bit done, mr;
        int lows;
        op = ins[15:14];
        fn = ins[13:8];
        q.push_back(PH_FETCH);
        q.push_back(PH_DECODE);
        if (op == 2'b01) begin
            q.push_back(PH_MEMADR);
            if (fn[0]) begin q.push_back(PH_MEMRD); q.push_back(PH_MEMWB); end
            else q.push_back(PH_MEMWR);
        end else if (op == 2'b10) begin
            q.push_back(PH_BRANCH);
        end else if (op == 2'b00 && dp_info(fn[4:1]) >= 4'b1000) begin
            q.push_back(fn[5] ? PH_EXECI : PH_EXECR);
            q.push_back(PH_ALUWB);
        end
        cyc = 0; rw = 0; adr = 0; mw = 0; pcw = 0;
        foreach (q[i]) begin
            lows = 0;
            do begin
                if (mlow >= 0) mr = (lows >= mlow);
                else mr = (lows >= 6) || ($urandom_range(0, 2) != 0);
                af = rand_af ? 4'($urandom) : af_fix;
                step(q[i], ins, mr, af, hs, done, obs);
                cyc++; lows++;
                rw  += int'(obs[17]);
                adr += int'(obs[20]);
                mw  += int'(obs[19]);
                pcw += int'(obs[21]);
            end while (!done);
        end
        $display("instr=%h hs=%0d cycles=%0d regwrite=%0d memwrite=%0d pcwrite=%0d", ins, hs, cyc, rw, mw, pcw);
    endtask

    function automatic logic [19:0] rand_instr();
        logic [19:0] r;
        logic [3:0] cmds [0:4];
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100; cmds[4] = 4'b1101;
        r = 20'($urandom);
        if (r[15:14] == 2'b00 && $urandom_range(0, 4) != 0) r[12:9] = cmds[$urandom_range(0, 4)];
        return r;
    endfunction

    task automatic test_reset();
        bit done;
        logic [21:0] obs;
        do_reset();
        step(PH_FETCH, 20'h0, 1'b0, 4'h0, 1'b1, done, obs);
    endtask

    task automatic test_add_nohs();
        int cyc, rw, adr, mw, pcw;
        do_reset();
        run_instr({4'hE, 2'b00, 6'b001000, 4'h2, 4'h1}, 1'b0, -1, 1'b1, 4'h0, cyc, rw, adr, mw, pcw);
        checks++;
        if (cyc != 4) begin errors++; $display("FAIL add_cycles got=%0d want=4", cyc); end
        checks++;
        if (rw != 1) begin errors++; $display("FAIL add_regwrite got=%0d want=1", rw); end
    endtask

    task automatic test_ldr_stall();
        int cyc, rw, adr, mw, pcw;
        do_reset();
        run_instr({4'hE, 2'b01, 6'b011001, 4'h3, 4'h2}, 1'b1, 3, 1'b1, 4'h0, cyc, rw, adr, mw, pcw);
        checks++;
        if (adr != 4) begin errors++; $display("FAIL ldr_memrd_cycles got=%0d want=4", adr); end
        checks++;
        if (rw != 1) begin errors++; $display("FAIL ldr_regwrite got=%0d want=1", rw); end
        checks++;
        if (cyc != 11) begin errors++; $display("FAIL ldr_cycles got=%0d want=11", cyc); end
    endtask

    task automatic test_flags_branch();
        int cyc, rw, adr, mw, pcw;
        do_reset();
        run_instr({4'hE, 2'b00, 6'b000101, 4'h1, 4'h1}, 1'b1, 0, 1'b0, 4'b0100, cyc, rw, adr, mw, pcw);
        checks++;
        if (o1[3:0] !== 4'b0100) begin errors++; $display("FAIL subs_flags got=%b want=0100", o1[3:0]); end
        run_instr({4'h0, 2'b10, 6'b100000, 4'h0, 4'h0}, 1'b1, 0, 1'b1, 4'h0, cyc, rw, adr, mw, pcw);
        checks++;
        if (pcw != 2 || cyc != 3) begin errors++; $display("FAIL beq_taken pcwrite=%0d cycles=%0d want 2 and 3", pcw, cyc); end
        run_instr({4'h1, 2'b10, 6'b100000, 4'h0, 4'h0}, 1'b1, 0, 1'b1, 4'h0, cyc, rw, adr, mw, pcw);
        checks++;
        if (pcw != 1) begin errors++; $display("FAIL bne_not_taken pcwrite=%0d want=1", pcw); end
    endtask

    task automatic test_str_cond();
        int cyc, rw, adr, mw, pcw;
        do_reset();
        run_instr({4'hE, 2'b00, 6'b001001, 4'h1, 4'h1}, 1'b1, 0, 1'b0, 4'b0000, cyc, rw, adr, mw, pcw);
        run_instr({4'h0, 2'b01, 6'b011000, 4'h1, 4'h2}, 1'b1, 2, 1'b1, 4'h0, cyc, rw, adr, mw, pcw);
        checks++;
        if (mw != 0 || cyc != 8) begin errors++; $display("FAIL streq_suppressed memwrite=%0d cycles=%0d want 0 and 8", mw, cyc); end
        run_instr({4'hE, 2'b01, 6'b011000, 4'h1, 4'h2}, 1'b1, 2, 1'b1, 4'h0, cyc, rw, adr, mw, pcw);
        checks++;
        if (mw != 3) begin errors++; $display("FAIL str_memwrite got=%0d want=3", mw); end
    endtask

    task automatic test_illegal();
        int cyc, rw, adr, mw, pcw;
        do_reset();
        run_instr({4'hE, 2'b11, 6'b000000, 4'h0, 4'h1}, 1'b1, 0, 1'b1, 4'h0, cyc, rw, adr, mw, pcw);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL illegal_op_cycles got=%0d want=2", cyc); end
        run_instr({4'hE, 2'b00, 6'b000010, 4'h0, 4'h1}, 1'b1, 0, 1'b1, 4'h0, cyc, rw, adr, mw, pcw);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL illegal_cmd_cycles got=%0d want=2", cyc); end
    endtask

    task automatic test_reset_midstall();
        int cyc, rw, adr, mw, pcw;
        bit done;
        logic [21:0] obs;
        logic [19:0] ldr;
        ldr = {4'hE, 2'b01, 6'b011001, 4'h3, 4'h2};
        do_reset();
        run_instr({4'hE, 2'b00, 6'b001001, 4'h1, 4'h1}, 1'b1, 0, 1'b0, 4'b1111, cyc, rw, adr, mw, pcw);
        step(PH_FETCH, ldr, 1'b1, 4'h0, 1'b1, done, obs);
        step(PH_DECODE, ldr, 1'b1, 4'h0, 1'b1, done, obs);
        step(PH_MEMADR, ldr, 1'b1, 4'h0, 1'b1, done, obs);
        step(PH_MEMRD, ldr, 1'b0, 4'h0, 1'b1, done, obs);
        step(PH_MEMRD, ldr, 1'b0, 4'h0, 1'b1, done, obs);
        do_reset();
        step(PH_FETCH, ldr, 1'b0, 4'h0, 1'b1, done, obs);
        checks++;
        if (obs[3:0] !== 4'b0000) begin errors++; $display("FAIL midstall_flags got=%b want=0000", obs[3:0]); end
    endtask

    task automatic test_random(input bit hs, input int n);
        int cyc, rw, adr, mw, pcw;
        do_reset();
        for (int i = 0; i < n; i++)
            run_instr(rand_instr(), hs, -1, 1'b1, 4'h0, cyc, rw, adr, mw, pcw);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_nohs();
        test_ldr_stall();
        test_flags_branch();
        test_str_cond();
        test_illegal();
        test_reset_midstall();
        test_random(1'b1, 60);
        test_random(1'b0, 30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
